// File: rtl/soc_system_mem_arb_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
package soc_system_mem_arb_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 64;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // Master index: 0 = HPS lightweight bridge, 1 = acquisition engine.
  typedef logic mst_idx_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] address;
    logic [BE_W_DEF-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_W_DEF-1:0] writedata;
  } req_bundle_t;

  // The master that did not win last time.
  function automatic mst_idx_t other_master(mst_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/soc_system_rr_arb2.sv
// Two-way round-robin grant with the last-grant history register.
// Under contention the master that was not served last wins; a lone
// requester is always granted.
module soc_system_rr_arb2
  import soc_system_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  mst_idx_t last_grant_q;
  mst_idx_t last_grant_d;

  // Combinational grant from the current requests and history.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant[other_master(last_grant_q)] = 1'b1;
      default: grant = 2'b00;
    endcase
  end

  // History follows whoever was served on a granted cycle.
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) last_grant_d = grant[1];
  end

  // Reset to master 1 so master 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/soc_system_onchip_memory_arbiter.sv
// Two-master Avalon-MM style arbiter in front of the single-port 8192x64
// on-chip RAM. One access per clock, fair round-robin, read data returned
// one cycle after the accepted read (RAM registers the address only).
// Optional contention-stall counters: define SOC_SYSTEM_MEM_ARB_PERF_EN.
module soc_system_onchip_memory_arbiter
  import soc_system_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              perf_clear,
  output logic [31:0]       perf_stall_m0,
  output logic [31:0]       perf_stall_m1
);

  logic        rdy_q;
  logic [1:0]  req;
  logic [1:0]  grant;
  req_bundle_t m0_b, m1_b, sel_b;
  logic        rd_accept;
  logic        rd_tag_valid_q, rd_tag_valid_d;
  mst_idx_t    rd_tag_q, rd_tag_d;

  // Hold both masters off until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  assign m0_b.address    = m0_address;
  assign m0_b.byteenable = m0_byteenable;
  assign m0_b.read       = m0_read;
  assign m0_b.write      = m0_write;
  assign m0_b.writedata  = m0_writedata;
  assign m1_b.address    = m1_address;
  assign m1_b.byteenable = m1_byteenable;
  assign m1_b.read       = m1_read;
  assign m1_b.write      = m1_write;
  assign m1_b.writedata  = m1_writedata;

  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{rdy_q}};

  soc_system_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (reset),
    .req     (req),
    .advance (|grant),
    .grant   (grant)
  );

  assign m0_waitrequest = ~grant[0];
  assign m1_waitrequest = ~grant[1];

  // Idle cycles leave master 0 on the RAM bus with chipselect low.
  assign sel_b          = grant[1] ? m1_b : m0_b;
  assign mem_chipselect = |grant;
  assign mem_address    = sel_b.address;
  assign mem_byteenable = sel_b.byteenable;
  assign mem_writedata  = sel_b.writedata;
  assign mem_write      = mem_chipselect & sel_b.write;
  assign mem_clken      = 1'b1;

  // Read+write together is treated as a write, so it never returns data.
  assign rd_accept = mem_chipselect & sel_b.read & ~sel_b.write;

  // Remember which master owns the data the RAM presents next cycle.
  always_comb begin
    rd_tag_valid_d = rd_accept;
    rd_tag_d       = rd_tag_q;
    if (rd_accept) rd_tag_d = grant[1];
  end

  // Async reset drops any in-flight read tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_tag_valid_q <= 1'b0;
      rd_tag_q       <= 1'b0;
    end else begin
      rd_tag_valid_q <= rd_tag_valid_d;
      rd_tag_q       <= rd_tag_d;
    end
  end

  assign m0_readdatavalid = rd_tag_valid_q & (rd_tag_q == 1'b0);
  assign m1_readdatavalid = rd_tag_valid_q & (rd_tag_q == 1'b1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

`ifdef SOC_SYSTEM_MEM_ARB_PERF_EN
  logic [31:0] stall0_q, stall0_d, stall1_q, stall1_d;

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count requested-but-refused cycles; clear beats a same-cycle increment.
  always_comb begin
    stall0_d = stall0_q;
    stall1_d = stall1_q;
    if (perf_clear) begin
      stall0_d = '0;
      stall1_d = '0;
    end else begin
      if (req[0] & ~grant[0]) stall0_d = sat_inc(stall0_q);
      if (req[1] & ~grant[1]) stall1_d = sat_inc(stall1_q);
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      stall0_q <= stall0_d;
      stall1_q <= stall1_d;
    end
  end

  assign perf_stall_m0 = stall0_q;
  assign perf_stall_m1 = stall1_q;
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;
  assign perf_stall_m0     = '0;
  assign perf_stall_m1     = '0;
`endif

endmodule

// File: tb/tb_soc_system_onchip_memory_arbiter.sv
// Randomised bench for the two-master on-chip RAM arbiter with a
// behavioural RAM and a transaction-level reference model.
module tb_soc_system_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [7:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [63:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [63:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [63:0] mem_writedata, mem_readdata;
  logic        perf_clear;
  logic [31:0] perf_stall_m0, perf_stall_m1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  soc_system_onchip_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .perf_clear(perf_clear), .perf_stall_m0(perf_stall_m0), .perf_stall_m1(perf_stall_m1)
  );

  function automatic logic [63:0] init_word(logic [12:0] a);
    return {16'hC0DE, 3'b000, a, 32'h0000BEEF};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM: registered address, unregistered q, byte-lane writes.
  logic [63:0] ram [0:8191];
  logic [12:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 8; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Reference model state: transaction view of the arbiter.
  logic [63:0] shadow [0:8191];
  bit          m_rdy = 1'b0;
  bit          m_last = 1'b1;
  bit          pv = 1'b0;
  bit          pwho = 1'b0;
  logic [63:0] pdata = '0;
  logic [31:0] mp0 = '0, mp1 = '0;
  bit          acc0 = 1'b0, acc1 = 1'b0;

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clk) begin : cmp
    bit r0, r1, e0, e1, any, srd, swr, ev0, ev1;
    logic [12:0] sa;
    logic [7:0]  sbe;
    logic [63:0] sd;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    e0 = 1'b0; e1 = 1'b0;
    if (!reset && m_rdy) begin
      if (r0 && r1) begin e0 = (m_last == 1'b1); e1 = !e0; end
      else begin e0 = r0; e1 = r1; end
    end
    any = e0 | e1;
    srd = e1 ? m1_read : m0_read;
    swr = e1 ? m1_write : m0_write;
    sa  = e1 ? m1_address : m0_address;
    sbe = e1 ? m1_byteenable : m0_byteenable;
    sd  = e1 ? m1_writedata : m0_writedata;
    chk("m0_waitrequest", m0_waitrequest, !e0);
    chk("m1_waitrequest", m1_waitrequest, !e1);
    chk("mem_chipselect", mem_chipselect, any);
    chk("mem_clken", mem_clken, 1'b1);
    chk("mem_address", mem_address, sa);
    if (any) begin
      chk("mem_write", mem_write, swr);
      if (swr) begin
        chk("mem_byteenable", mem_byteenable, sbe);
        chk("mem_writedata", mem_writedata, sd);
      end
    end
    ev0 = !reset && pv && (pwho == 1'b0);
    ev1 = !reset && pv && (pwho == 1'b1);
    chk("m0_readdatavalid", m0_readdatavalid, ev0);
    chk("m1_readdatavalid", m1_readdatavalid, ev1);
    if (ev0) chk("m0_readdata", m0_readdata, pdata);
    if (ev1) chk("m1_readdata", m1_readdata, pdata);
`ifdef SOC_SYSTEM_MEM_ARB_PERF_EN
    chk("perf_stall_m0", perf_stall_m0, reset ? 32'd0 : mp0);
    chk("perf_stall_m1", perf_stall_m1, reset ? 32'd0 : mp1);
`else
    chk("perf_stall_m0", perf_stall_m0, 32'd0);
    chk("perf_stall_m1", perf_stall_m1, 32'd0);
`endif
    acc0 = e0;
    acc1 = e1;
    if (reset) begin
      m_rdy = 1'b0; m_last = 1'b1; pv = 1'b0; mp0 = '0; mp1 = '0;
    end else begin
      pv = any && srd && !swr;
      pwho = e1;
      if (pv) pdata = shadow[sa];
      if (any && swr)
        for (int b = 0; b < 8; b++)
          if (sbe[b]) shadow[sa][b*8 +: 8] = sd[b*8 +: 8];
      if (any) m_last = e1;
      if (perf_clear) begin
        mp0 = '0; mp1 = '0;
      end else begin
        if (m_rdy && r0 && !e0 && mp0 != 32'hFFFF_FFFF) mp0 = mp0 + 1;
        if (m_rdy && r1 && !e1 && mp1 != 32'hFFFF_FFFF) mp1 = mp1 + 1;
      end
      m_rdy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(bit rd, bit wr, logic [12:0] a, logic [7:0] be, logic [63:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(bit rd, bit wr, logic [12:0] a, logic [7:0] be, logic [63:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  // Run until every pending request has been accepted, dropping each on acceptance.
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc0) set_m0(0, 0, '0, '0, '0);
      if (acc1) set_m1(0, 0, '0, '0, '0);
      if (!(m0_read | m0_write | m1_read | m1_write)) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  initial begin : stim
    bit          w0, w1, p0;
    int          t0, t1;
    logic [63:0] d0, d1;
    bit          seen;
    for (int a = 0; a < 8192; a++) begin
      ram[a] = init_word(13'(a));
      shadow[a] = init_word(13'(a));
    end
    reset = 1'b1;
    perf_clear = 1'b0;
    set_m0(1, 0, 13'h0010, 8'hFF, '0);
    set_m1(0, 0, '0, '0, '0);

    // Reset: both masters held off, RAM deselected.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    tick();
    reset = 1'b0;
    drain();
    @(negedge clk);
    chk("first_read_rdv0", m0_readdatavalid, 1);
    chk("first_read_data", m0_readdata, 64'hC0DE0010_0000BEEF);
    chk("first_read_rdv1", m1_readdatavalid, 0);
    tick();

    // Continuous contention: grants must alternate.
    set_m0(0, 1, 13'h0100, 8'hFF, 64'h0101_0101_0101_0101);
    set_m1(0, 1, 13'h0200, 8'hFF, 64'h0202_0202_0202_0202);
    p0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w0 = m0_waitrequest; w1 = m1_waitrequest;
      chk("contend_one_grant", w0 ^ w1, 1);
      if (i > 0) chk("contend_alternate", w0, !p0);
      p0 = w0;
      tick();
    end
    drain();

    // Byte lanes: full write then low-half write, read back by m0 only.
    set_m1(0, 1, 13'h1FFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    set_m1(0, 1, 13'h1FFF, 8'h0F, 64'h1122_3344_5566_7788);
    drain();
    set_m0(1, 0, 13'h1FFF, 8'hFF, '0);
    drain();
    @(negedge clk);
    chk("lanes_rdv0", m0_readdatavalid, 1);
    chk("lanes_data", m0_readdata, 64'hFFFF_FFFF_5566_7788);
    chk("lanes_rdv1", m1_readdatavalid, 0);
    tick();

    // Interleaved reads from both masters.
    set_m0(1, 0, 13'h0001, 8'hFF, '0);
    set_m1(1, 0, 13'h0002, 8'hFF, '0);
    t0 = -1; t1 = -1; d0 = '0; d1 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m0_readdatavalid) begin t0 = i; d0 = m0_readdata; end
      if (m1_readdatavalid) begin t1 = i; d1 = m1_readdata; end
      tick();
      if (acc0) set_m0(0, 0, '0, '0, '0);
      if (acc1) set_m1(0, 0, '0, '0, '0);
    end
    chk("inter_adjacent", ((t0 - t1 == 1) || (t1 - t0 == 1)) && t0 >= 0 && t1 >= 0, 1);
    chk("inter_data0", d0, 64'hC0DE0001_0000BEEF);
    chk("inter_data1", d1, 64'hC0DE0002_0000BEEF);

    // Reset in the cycle after an accepted m1 read.
    set_m1(1, 0, 13'h0005, 8'hFF, '0);
    drain();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_rdv1", m1_readdatavalid, 0);
      tick();
    end
    reset = 1'b0;
    set_m0(1, 0, 13'h0006, 8'hFF, '0);
    set_m1(1, 0, 13'h0007, 8'hFF, '0);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (!m0_waitrequest || !m1_waitrequest) begin
        chk("postrst_m0_first", m0_waitrequest, 0);
        seen = 1'b1;
      end else begin
        tick();
      end
    end
    chk("postrst_grant_seen", seen, 1);
    drain();
    tick();

`ifdef SOC_SYSTEM_MEM_ARB_PERF_EN
    // Stall counters: 10 contended cycles split 5/5, then clear during a stall.
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    set_m0(0, 1, 13'h0300, 8'hFF, 64'h3);
    set_m1(0, 1, 13'h0301, 8'hFF, 64'h4);
    repeat (10) tick();
    perf_clear = 1'b1;
    @(negedge clk);
    chk("perf_m0_5", perf_stall_m0, 32'd5);
    chk("perf_m1_5", perf_stall_m1, 32'd5);
    tick();
    perf_clear = 1'b0;
    @(negedge clk);
    chk("perf_clr_m0", perf_stall_m0, 32'd0);
    chk("perf_clr_m1", perf_stall_m1, 32'd0);
    drain();
`endif

    // Random traffic on a small address window to provoke read-after-write.
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      perf_clear = ($urandom_range(0, 49) == 0);
      if (acc0 || !(m0_read | m0_write)) begin
        r = $urandom_range(0, 9);
        set_m0(r >= 3 && r <= 5 || r == 9, r >= 6, 13'($urandom_range(0, 15)),
               8'($urandom), {$urandom, $urandom});
      end
      if (acc1 || !(m1_read | m1_write)) begin
        r = $urandom_range(0, 9);
        set_m1(r >= 3 && r <= 5 || r == 9, r >= 6, 13'($urandom_range(0, 15)),
               8'($urandom), {$urandom, $urandom});
      end
    end
    reset = 1'b0;
    perf_clear = 1'b0;
    set_m0(0, 0, '0, '0, '0);
    set_m1(0, 0, '0, '0, '0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
